// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU. It grants one request per cycle,
// registers results with latency 1, and owns the shared NZCV status register.
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [3:0]  req0_cmd,
    input  logic [31:0] req0_val1,
    input  logic [31:0] req0_val2,
    input  logic        req0_s,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_cmd,
    input  logic [31:0] req1_val1,
    input  logic [31:0] req1_val2,
    input  logic        req1_s,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_res,
    output logic [3:0]  rsp0_status,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_res,
    output logic [3:0]  rsp1_status,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic        alu_carry_in,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_status,
    output logic [3:0]  status_reg
);

    localparam bit RR_ON = (RR_EN != 32'sd0);

    // prio_r names the port that wins the next contention; reset value favours port 0.
    logic        prio_r;
    logic        grant0_s;
    logic        grant1_s;
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic [31:0] rsp0_res_r;
    logic [31:0] rsp1_res_r;
    logic [3:0]  rsp0_status_r;
    logic [3:0]  rsp1_status_r;
    logic [3:0]  status_reg_r;

    // Grant selection from the valids and the priority pointer only
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (RR_ON && prio_r) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    // Steer the granted port's operation onto the shared ALU, zeros when idle
    always_comb begin
        alu_cmd  = 4'b0000;
        alu_val1 = 32'd0;
        alu_val2 = 32'd0;
        if (grant0_s) begin
            alu_cmd  = req0_cmd;
            alu_val1 = req0_val1;
            alu_val2 = req0_val2;
        end else if (grant1_s) begin
            alu_cmd  = req1_cmd;
            alu_val1 = req1_val1;
            alu_val2 = req1_val2;
        end else begin
            alu_cmd  = 4'b0000;
            alu_val1 = 32'd0;
            alu_val2 = 32'd0;
        end
    end

    assign req0_ready   = grant0_s;
    assign req1_ready   = grant1_s;
    assign alu_carry_in = status_reg_r[1];

    // Response capture, status update and pointer rotation on each granted edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r        <= 1'b0;
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp0_res_r    <= 32'd0;
            rsp1_res_r    <= 32'd0;
            rsp0_status_r <= 4'b0000;
            rsp1_status_r <= 4'b0000;
            status_reg_r  <= 4'b0000;
        end else begin
            rsp0_valid_r <= grant0_s;
            rsp1_valid_r <= grant1_s;
            if (grant0_s) begin
                rsp0_res_r    <= alu_res;
                rsp0_status_r <= alu_status;
            end
            if (grant1_s) begin
                rsp1_res_r    <= alu_res;
                rsp1_status_r <= alu_status;
            end
            if ((grant0_s && req0_s) || (grant1_s && req1_s)) begin
                status_reg_r <= alu_status;
            end
            // The loser of this grant gets priority next time; idle cycles keep it.
            if (grant0_s) begin
                prio_r <= 1'b1;
            end else if (grant1_s) begin
                prio_r <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = rsp0_valid_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp0_res    = rsp0_res_r;
    assign rsp1_res    = rsp1_res_r;
    assign rsp0_status = rsp0_status_r;
    assign rsp1_status = rsp1_status_r;
    assign status_reg  = status_reg_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 winning.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- reqN_valid  in  1  requester N (N=0,1) presents an operation.
- reqN_cmd  in  4  EXE_CMD encoding for requester N.
- reqN_val1, reqN_val2  in  32  operands for requester N.
- reqN_s  in  1  requester N's operation updates the status register.
- reqN_ready  out  1  requester N's operation is accepted this cycle.
- rspN_valid  out  1  result for requester N is present this cycle.
- rspN_res  out  32  result for requester N.
- rspN_status  out  4  {N,Z,C,V} for requester N.
- alu_cmd  out  4  command driven to the shared ALU.
- alu_val1, alu_val2  out  32  operands driven to the shared ALU.
- alu_carry_in  out  1  carry driven to the shared ALU.
- alu_res  in  32  ALU result (combinational from the alu_* outputs).
- alu_status  in  4  ALU flags {N,Z,C,V} (combinational from the alu_* outputs).
- status_reg  out  4  shared architectural NZCV register.

Function
REQ-003 At most one request SHALL be granted per cycle; a grant is signalled by reqN_ready=1 in the same cycle as reqN_valid=1.
REQ-004 reqN_ready SHALL be a combinational function of the valid inputs and the priority pointer only; it SHALL NOT depend on the cmd, val or s inputs.
REQ-005 With only one valid request, that request SHALL be granted.
REQ-006 With both requests valid and RR_EN=1, the port not granted most recently SHALL win.
REQ-007 With both requests valid and RR_EN=0, port 0 SHALL win.
REQ-008 The last-granted pointer SHALL update only on a grant; idle cycles SHALL leave it unchanged.
REQ-009 An ungranted request SHALL be held by its requester with stable cmd, val and s until ready=1; the arbiter SHALL NOT drop or reorder it.
REQ-010 alu_cmd, alu_val1 and alu_val2 SHALL combinationally mirror the granted port's inputs.
REQ-011 With no grant, alu_cmd SHALL be 4'b0000 and alu_val1 and alu_val2 SHALL be 0.
REQ-012 alu_carry_in SHALL equal status_reg[1] (C) as registered before the current edge.
REQ-013 On the edge ending a grant cycle, the block SHALL:
- capture alu_res and alu_status into the granted port's rspN_res and rspN_status;
- set that port's rspN_valid=1 for exactly one cycle, giving latency 1.
REQ-014 rspN_res and rspN_status SHALL hold their last values while rspN_valid=0.
REQ-015 Responses have no backpressure; the requester SHALL sample them while rspN_valid=1.
REQ-016 On the same edge, status_reg SHALL load alu_status if the granted reqN_s=1; otherwise status_reg SHALL hold.
REQ-017 For back-to-back operations, carry SHALL chain: an ADC granted in the cycle after an S=1 ADD SHALL use that ADD's C.
REQ-018 Simultaneous grant and response in the same cycle SHALL be legal, with full throughput of one operation per cycle.
REQ-019 rsp0_valid and rsp1_valid SHALL never be 1 in the same cycle.

Reset
REQ-020 While rst=1 at an edge, the block SHALL clear all of: rspN_valid, rspN_res, rspN_status, status_reg, and the pointer.
REQ-021 After reset, the pointer SHALL make port 0 the winner of the first contention.
REQ-022 During rst=1, reqN_ready SHALL be 0 and no operation SHALL be accepted.
REQ-023 If rst is asserted in a grant cycle, that operation SHALL be discarded: no response and no status update.

Verification
REQ-024 Contention: req0 ADD 5+3 and req1 SUB 5-5 both valid from cycle 0 -> cycle 0 ready0=1 and ready1=0; cycle 1 rsp0_valid=1 with res=8 and ready1=1; cycle 2 rsp1_valid=1 with res=0 and status=4'b0100.
REQ-025 Round-robin: both ports valid for 4 cycles -> grants alternate 0,1,0,1; with RR_EN=0 -> grants are 0,0,0,0.
REQ-026 Carry chain: req0 ADD 0xFFFFFFFF+0x1 with S=1, then ADC 0+0 -> first rsp res=0 and status=4'b0110 with status_reg=4'b0110; second rsp res=1.
REQ-027 S=0: SUB 1-2 with S=0 after status_reg=4'b0110 -> rsp status=4'b1010 and res=0xFFFFFFFF, while status_reg stays 4'b0110.
REQ-028 Reset mid-operation: assert rst in the cycle req1 is granted -> the next cycle has no rsp1_valid, status_reg=0, and a subsequent contention grants port 0 first.
REQ-029 Idle: no valid for 3 cycles -> alu_cmd=0, no rspN_valid, and status_reg and pointer unchanged.
